sig_capture: RTL and testbench

Triggered capture buffer: records `mic_signal` continuously into an internal circular RAM once armed, freezes after a level-crossing trigger plus a programmable post-trigger sample count, then streams the frozen window out oldest-first through a request/valid read port. It is the read-side companion to the continuous delay path: the delay path writes and replays in real time, while `sig_capture` holds a snapshot for a host or display to drain at its own pace. It sits on the same sample clock as the microphone front end.

---
 rtl/sig_capture.sv | 186 ++++++++++++++++++
 tb/tb_sig_capture.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sig_capture.sv
// sig_capture: triggered capture buffer. Records mic_signal into a circular
// RAM once armed, freezes a programmable number of samples after a rising
// level crossing, then streams the frozen window out oldest-first.
// Optional feature macro: SIG_CAPTURE_AUTOTRIG_EN (force a trigger after N
// untriggered writes and flag it on auto_trig).
module sig_capture #(
    parameter int unsigned A_WIDTH = 9,
    parameter int unsigned D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic [D_WIDTH-1:0] trig_level,
    input  logic [A_WIDTH-1:0] post_count,
    input  logic [D_WIDTH-1:0] mic_signal,
    input  logic               rd_req,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    output logic               rd_last,
    output logic               auto_trig
);

    localparam int unsigned DEPTH = 1 << A_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_DONE  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [A_WIDTH-1:0] wr_ptr;
    logic [A_WIDTH-1:0] wr_ptr_inc;
    logic [A_WIDTH-1:0] rd_ptr;
    logic [A_WIDTH-1:0] rd_cnt;
    logic [A_WIDTH-1:0] post_cnt;
    logic [D_WIDTH-1:0] prev;
    logic               start;
    logic               wr_en;
    logic               rd_en;
    logic               rd_final;
    logic               level_hit;
    logic               trig;

    assign wr_ptr_inc = wr_ptr + A_WIDTH'(1);
    assign rd_final   = (rd_cnt == {A_WIDTH{1'b1}});
    // prev is all-ones after arming, so the first sample can never qualify
    assign level_hit  = (prev < trig_level) && (mic_signal >= trig_level);

`ifdef SIG_CAPTURE_AUTOTRIG_EN
    logic [A_WIDTH-1:0] samp_cnt;
    logic               auto_hit;

    assign auto_hit = (state == S_ARMED) && !level_hit && (samp_cnt == {A_WIDTH{1'b1}});
    assign trig     = level_hit || auto_hit;

    // Count armed writes; the Nth untriggered write becomes the trigger sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt  <= '0;
            auto_trig <= 1'b0;
        end else if (start) begin
            samp_cnt  <= '0;
            auto_trig <= 1'b0;
        end else if (state == S_ARMED) begin
            samp_cnt <= samp_cnt + A_WIDTH'(1);
            if (auto_hit) begin
                auto_trig <= 1'b1;
            end
        end
    end
`else
    assign trig      = level_hit;
    assign auto_trig = 1'b0;
`endif

    // Next-state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    start     = 1'b1;
                    state_nxt = S_ARMED;
                end
            end
            S_ARMED: begin
                wr_en = 1'b1;
                if (trig) begin
                    state_nxt = (post_count == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                wr_en = 1'b1;
                if (post_cnt == A_WIDTH'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE, S_READ: begin
                if (rd_req) begin
                    rd_en     = 1'b1;
                    state_nxt = rd_final ? S_IDLE : S_READ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt == S_ARMED) || (state_nxt == S_POST);
            done     <= (state_nxt == S_DONE) || (state_nxt == S_READ);
            rd_valid <= rd_en;
            rd_last  <= rd_en && rd_final;
        end
    end

    // Write side: pointer, crossing history and post-trigger countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            prev     <= '0;
            post_cnt <= '0;
        end else begin
            if (start) begin
                wr_ptr <= '0;
                prev   <= '1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (state == S_ARMED) begin
                prev <= mic_signal;
                if (trig) begin
                    post_cnt <= post_count;
                end
            end else if (state == S_POST) begin
                post_cnt <= post_cnt - A_WIDTH'(1);
            end
        end
    end

    // Sample RAM write port (contents survive reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= mic_signal;
        end
    end

    // Read side: the next write slot is the oldest sample once frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            rd_cnt  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en && (state_nxt == S_DONE)) begin
                rd_ptr <= wr_ptr_inc;
                rd_cnt <= '0;
            end
            if (rd_en) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + A_WIDTH'(1);
                rd_cnt  <= rd_cnt + A_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sig_capture.sv
// tb_sig_capture: randomized self-checking bench for sig_capture (N = 16).
module tb_sig_capture;

    localparam int unsigned A = 4;
    localparam int unsigned D = 8;
    localparam int unsigned N = 1 << A;

    logic         clk = 1'b0;
    logic         rst;
    logic         arm;
    logic [D-1:0] trig_level;
    logic [A-1:0] post_count;
    logic [D-1:0] mic_signal;
    logic         rd_req;
    logic         busy;
    logic         done;
    logic [D-1:0] rd_data;
    logic         rd_valid;
    logic         rd_last;
    logic         auto_trig;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each RAM slot holds and how many writes since arm
    logic [D-1:0] m_mem   [N];
    bit           m_known [N];
    int           m_wcnt;
    bit           m_auto;
    logic [D-1:0] m_last;
    logic [D-1:0] m_trig_val;
    logic [D-1:0] rd_log  [N];

    sig_capture #(.A_WIDTH(A), .D_WIDTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .trig_level (trig_level),
        .post_count (post_count),
        .mic_signal (mic_signal),
        .rd_req     (rd_req),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_last    (rd_last),
        .auto_trig  (auto_trig)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Sample generator: 0 random, 1 ramp by 0x10, 2 constant 0xFF, 3 low then 0x7F,0x80
    function automatic logic [D-1:0] gen(input int mode, input int k);
        logic [D-1:0] s;
        case (mode)
            1:       s = D'(k * 16);
            2:       s = 8'hFF;
            3:       s = (k < 10) ? D'($urandom_range(0, 8'h7E)) : ((k == 10) ? 8'h7F : 8'h80);
            default: s = D'($urandom);
        endcase
        return s;
    endfunction

    // Arm, feed samples, and check busy/done/auto_trig against the model each cycle
    task automatic run_capture(input logic [D-1:0] lvl, input int pc, input int mode,
                               input int budget, output bit finished);
        int           prev;
        bit           post;
        int           rem;
        bit           t;
        logic [D-1:0] s;
        trig_level = lvl;
        post_count = A'(pc);
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || auto_trig !== 1'b0) begin
            n_fail++;
            $display("FAIL arm_ack: busy=%b done=%b auto=%b, want busy=1 done=0 auto=0",
                     busy, done, auto_trig);
        end
        prev     = 255;
        post     = 0;
        rem      = 0;
        m_wcnt   = 0;
        m_auto   = 0;
        finished = 0;
        for (int k = 0; k < budget && !finished; k++) begin
            s          = gen(mode, k);
            mic_signal = s;
            tick();
            m_mem[A'(m_wcnt)]   = s;
            m_known[A'(m_wcnt)] = 1'b1;
            m_wcnt++;
            m_last = s;
            if (!post) begin
                t = (prev < int'(lvl)) && (int'(s) >= int'(lvl));
`ifdef SIG_CAPTURE_AUTOTRIG_EN
                if (!t && m_wcnt == N) begin
                    t      = 1;
                    m_auto = 1;
                end
`endif
                prev = int'(s);
                if (t) begin
                    m_trig_val = s;
                    if (pc == 0) finished = 1;
                    else begin
                        post = 1;
                        rem  = pc;
                    end
                end
            end else begin
                rem--;
                if (rem == 0) finished = 1;
            end
            n_checks++;
            if (busy !== !finished || done !== finished || auto_trig !== m_auto) begin
                n_fail++;
                $display("FAIL capture_status write %0d: busy=%b done=%b auto=%b, want busy=%b done=%b auto=%b",
                         m_wcnt, busy, done, auto_trig, !finished, finished, m_auto);
            end
        end
    endtask

    // Drain the window with optional idle gaps and an arm pulse on read arm_at
    task automatic read_window(input int gap, input int arm_at);
        int base;
        int idx;
        base = m_wcnt % N;
        for (int i = 0; i < N; i++) begin
            rd_req = 1'b1;
            arm    = (i == arm_at);
            tick();
            rd_req    = 1'b0;
            arm       = 1'b0;
            rd_log[i] = rd_data;
            n_checks++;
            if (rd_valid !== 1'b1 || rd_last !== (i == N - 1) || done !== (i != N - 1) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL read_flags %0d: valid=%b last=%b done=%b busy=%b, want valid=1 last=%b done=%b busy=0",
                         i, rd_valid, rd_last, done, busy, (i == N - 1), (i != N - 1));
            end
            idx = (base + i) % N;
            if (m_known[idx]) begin
                n_checks++;
                if (rd_data !== m_mem[idx]) begin
                    n_fail++;
                    $display("FAIL read_data %0d: got %h, want %h", i, rd_data, m_mem[idx]);
                end
            end
            if (i < N - 1) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    n_checks++;
                    if (rd_valid !== 1'b0 || done !== 1'b1) begin
                        n_fail++;
                        $display("FAIL read_gap %0d: valid=%b done=%b, want valid=0 done=1",
                                 i, rd_valid, done);
                    end
                end
            end
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after_last: valid=%b done=%b busy=%b, want 0 0 0",
                     rd_valid, done, busy);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        arm        = 1'b0;
        rd_req     = 1'b0;
        trig_level = '0;
        post_count = '0;
        mic_signal = '0;
        tick();
        tick();
        n_checks++;
        if ({busy, done, rd_valid, rd_last, auto_trig} !== 5'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b done=%b valid=%b last=%b auto=%b data=%h, want all 0",
                     busy, done, rd_valid, rd_last, auto_trig, rd_data);
        end
        rst    = 1'b0;
        rd_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_rd_req %0d: valid=%b done=%b, want 0 0", c, rd_valid, done);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset_mid_post();
        bit fin;
        run_capture(8'h80, 10, 1, 12, fin);
        n_checks++;
        if (fin !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_post_setup: finished=%b busy=%b, want 0 1", fin, busy);
        end
        rd_req = 1'b1;
        rst    = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, rd_valid, rd_last, auto_trig} !== 5'b0 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b done=%b valid=%b last=%b auto=%b data=%h, want all 0",
                     busy, done, rd_valid, rd_last, auto_trig, rd_data);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle %0d: valid=%b busy=%b done=%b, want 0 0 0",
                         c, rd_valid, busy, done);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_ramp();
        bit           fin;
        logic [D-1:0] want;
        run_capture(8'h80, 4, 1, 100, fin);
        n_checks++;
        if (fin !== 1'b1) begin
            n_fail++;
            $display("FAIL ramp_finish: finished=%b, want 1", fin);
        end
        read_window(0, -1);
        for (int k = 0; k < 5; k++) begin
            want = D'(8'h80 + 16 * k);
            n_checks++;
            if (rd_log[N - 5 + k] !== want) begin
                n_fail++;
                $display("FAIL ramp_tail %0d: got %h, want %h", k, rd_log[N - 5 + k], want);
            end
        end
    endtask

    task automatic test_no_trigger();
        bit fin;
`ifdef SIG_CAPTURE_AUTOTRIG_EN
        run_capture(8'h01, 3, 2, 100, fin);
        n_checks++;
        if (fin !== 1'b1 || m_wcnt != N + 3 || auto_trig !== 1'b1) begin
            n_fail++;
            $display("FAIL autotrig: finished=%b writes=%0d auto=%b, want 1 %0d 1",
                     fin, m_wcnt, auto_trig, N + 3);
        end
        read_window(0, -1);
`else
        run_capture(8'h01, 3, 2, 100, fin);
        n_checks++;
        if (fin !== 1'b0 || busy !== 1'b1 || auto_trig !== 1'b0) begin
            n_fail++;
            $display("FAIL no_trigger: finished=%b busy=%b auto=%b, want 0 1 0", fin, busy, auto_trig);
        end
        pulse_reset();
`endif
    endtask

    task automatic test_post_zero();
        bit fin;
        run_capture(8'h80, 0, 3, 100, fin);
        n_checks++;
        if (fin !== 1'b1 || m_wcnt != 12) begin
            n_fail++;
            $display("FAIL post_zero_finish: finished=%b writes=%0d, want 1 12", fin, m_wcnt);
        end
        read_window(0, -1);
        n_checks++;
        if (rd_log[N - 1] !== 8'h80 || rd_log[N - 2] !== 8'h7F) begin
            n_fail++;
            $display("FAIL post_zero_tail: got %h %h, want 7f 80", rd_log[N - 2], rd_log[N - 1]);
        end
    endtask

    task automatic test_gapped_reads_arm();
        bit fin;
        run_capture(D'($urandom_range(8'h40, 8'hC0)), $urandom_range(1, N - 1), 0, 400, fin);
        if (fin) read_window(1, 5);
        else pulse_reset();
        run_capture(8'h80, 2, 1, 100, fin);
        n_checks++;
        if (fin !== 1'b1) begin
            n_fail++;
            $display("FAIL rearm_finish: finished=%b, want 1", fin);
        end
        read_window(0, -1);
    endtask

    task automatic test_wrap();
        bit fin;
        run_capture(8'h80, N - 1, 0, 400, fin);
        if (!fin) begin
            pulse_reset();
            return;
        end
        read_window(0, -1);
        n_checks++;
        if (rd_log[0] !== m_trig_val || rd_log[N - 1] !== m_last) begin
            n_fail++;
            $display("FAIL wrap_ends: first=%h last=%h, want %h %h",
                     rd_log[0], rd_log[N - 1], m_trig_val, m_last);
        end
    endtask

    task automatic test_random();
        bit fin;
        for (int it = 0; it < 6; it++) begin
            run_capture(D'($urandom_range(8'h10, 8'hF0)), $urandom_range(0, N - 1), 0, 400, fin);
            if (fin) read_window($urandom_range(0, 2), $urandom_range(1, N - 2));
            else pulse_reset();
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_known[i] = 1'b0;
        test_reset();
        test_reset_mid_post();
        test_ramp();
        test_no_trigger();
        test_post_zero();
        test_gapped_reads_arm();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
